// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// Multi-cycle fetch/decode/exec sequencer for the 2-bit-opcode core.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | out of reset, waiting for start
// S_FETCH  | imem_req high at pc, waiting for imem_ack
// S_DECODE | one cycle: map IR to control word or detect halt
// S_EXEC   | ctrl_valid high, waiting for ctrl_ready
// S_HALT   | halt instruction or fetch timeout; start restarts at PC_RESET
module instr_sequencer #(
  parameter int            AW             = 6,
  parameter logic [AW-1:0] PC_RESET       = '0,
  parameter int            TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [7:0]    imem_data,
  output logic          ctrl_valid,
  output logic [7:0]    ctrl_word,
  output logic [5:0]    ctrl_operand,
  input  logic          ctrl_ready,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t        state, state_next;
  logic [7:0]    ir;
  logic [AW-1:0] pc_q;
  logic [7:0]    word_q;
  logic [5:0]    operand_q;

  logic load_ir, load_ctrl, pc_inc, pc_restart, timeout;
  logic [7:0] word_dec;

  always_comb begin
    word_dec = 8'h00;
    case (ir[7:6])
      2'b00: word_dec = 8'hC1;
      2'b01: word_dec = 8'h6A;
      2'b10: word_dec = 8'hA4;
      2'b11: word_dec = 8'h12;
      default: word_dec = 8'h00;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;

  // imem_ack on the limit cycle takes priority over the timeout
  assign timeout = (state == S_FETCH) && !imem_ack &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state != S_FETCH)
        tcnt <= '0;
      else if (!imem_ack)
        tcnt <= tcnt + 1'b1;
      if (timeout)
        err_q <= 1'b1;
      else if (pc_restart)
        err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_next = state;
    load_ir    = 1'b0;
    load_ctrl  = 1'b0;
    pc_inc     = 1'b0;
    pc_restart = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          load_ir    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_HALT;
        end
      end
      S_DECODE: begin
        if (ir == 8'hFF) begin
          state_next = S_HALT;
        end else begin
          load_ctrl  = 1'b1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ctrl_ready) begin
          pc_inc     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_restart = 1'b1;
          state_next = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc_q      <= PC_RESET;
      ir        <= 8'h00;
      word_q    <= 8'h00;
      operand_q <= 6'h00;
    end else begin
      state <= state_next;
      if (load_ir)
        ir <= imem_data;
      if (load_ctrl) begin
        word_q    <= word_dec;
        operand_q <= ir[5:0];
      end
      if (pc_restart)
        pc_q <= PC_RESET;
      else if (pc_inc)
        pc_q <= pc_q + 1'b1;
    end
  end

  assign imem_req     = (state == S_FETCH);
  assign imem_addr    = imem_req ? pc_q : '0;
  assign ctrl_valid   = (state == S_EXEC);
  assign ctrl_word    = word_q;
  assign ctrl_operand = operand_q;
  assign pc           = pc_q;
  assign busy         = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign halted       = (state == S_HALT);

endmodule
